pipe_stage_reg: RTL

Parametrised successor to the fixed-field inter-stage pipeline registers (F/D, D/E, E/M, M/W). It is a 2-entry elastic stage with valid/ready handshake, so a stall at the back-end (e.g. multi-cycle MDU, bus wait) no longer needs a global freeze. It also provides synchronous flush, saturating Tnew decrement for the hazard unit, and first-exception-wins ExcCode merge. One instance per stage boundary; the payload width is set by each stage.

---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - 2-entry elastic inter-stage pipeline register
// Optional PIPE_PERF_CNT_EN adds stall_cnt/bubble_cnt outputs.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int TNEW_W = 2,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  stage_exc,
  input  logic              stage_exc_vld,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int ENT_W = DATA_W + TNEW_W + EXC_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   head;
  logic [ENT_W-1:0]   skid;
  logic [ENT_W-1:0]   capEntry;
  logic [TNEW_W-1:0]  capTnew;
  logic [EXC_W-1:0]   capExc;
  logic               inReadyReg;
  logic               accept;
  logic               drain;

  // Tnew is decremented once at capture so held entries never count down twice
  assign capTnew  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
  assign capExc   = (in_exc != '0) ? in_exc : (stage_exc_vld ? stage_exc : '0);
  assign capEntry = {in_data, capTnew, capExc, in_bd};

  assign in_ready  = inReadyReg;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & inReadyReg;
  assign drain     = out_valid & out_ready;

  // Head is zeroed whenever the stage empties, so a bubble reads as a NOP
  assign {out_data, out_tnew, out_exc, out_bd} = head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      head       <= '0;
      skid       <= '0;
      inReadyReg <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      head       <= '0;
      skid       <= '0;
      inReadyReg <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= capEntry;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head <= capEntry;
          end else if (accept) begin
            skid       <= capEntry;
            state      <= TWO;
            inReadyReg <= 1'b0;
          end else if (drain) begin
            head  <= '0;
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            head       <= skid;
            skid       <= '0;
            state      <= ONE;
            inReadyReg <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          head       <= '0;
          skid       <= '0;
          inReadyReg <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters survive flush so redirect storms still show up in the stats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
